hazard_scheduler: RTL and testbench
===================================

Name: hazard_scheduler

Overview:
- Issue/stall scheduler for the 4-stage pipeline (sf, s0, s1, s2, s3).
- Keeps a scoreboard of in-flight destination registers in s0..s3.
- Decides on each pipeline advance whether the instruction at sf enters s0 or a bubble is inserted.
- Arbitrates the single memory port between instruction fetch and s2 load/store, and sequences a drain/idle mode for the control unit.

Parameters:
- REG_ADDR_W, 5, register index width
- STALL_CNT_W, 16, width of saturating stall counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clk_enable  in  1  pipeline advance strobe; all state updates only when high
- sf_valid  in  1  decoded instruction present at sf
- sf_rs1  in  REG_ADDR_W  source register 1
- sf_rs2  in  REG_ADDR_W  source register 2
- sf_uses_rs1  in  1  rs1 is read
- sf_uses_rs2  in  1  rs2 is read
- sf_rd  in  REG_ADDR_W  destination register
- sf_writes_rd  in  1  instruction writes rd
- sf_is_mem  in  1  load or store (uses memory port in s2)
- flush  in  1  taken branch/jump; kill sf instruction
- drain_req  in  1  request pipeline drain
- issue  out  1  sf instruction enters s0 on this advance (comb)
- pc_hold  out  1  fetch PC must not increment on this advance (comb)
- mem_sel_data  out  1  memory port owned by s2 data access (registered)
- drained  out  1  state IDLE (registered)
- stall_count  out  STALL_CNT_W  saturating count of stall advances

Behaviour:
- Scoreboard: one entry per stage s0..s3 holding {valid, rd, writes_rd, is_mem}.
- Reset state: all valid=0, state RUN, stall_count=0, mem_sel_data=0, drained=0.
- Reset overrides clk_enable. A reset mid-operation discards all in-flight entries.
- On advance (clk_enable=1, rst=0):
  - s3 retires.
  - s2 moves to s3, s1 to s2, s0 to s1.
  - s0 is loaded with the sf entry if issue=1; otherwise with a bubble (valid=0).
- No state changes when clk_enable=0. Comb outputs still reflect current inputs.
- RAW hazard: an active source (uses=1, index!=0) equals rd of any entry in s0, s1 or s2 with valid=1 and writes_rd=1.
  - s3 is not a hazard: the register file writes before it reads.
  - rd=0 never causes a hazard.
- Structural hazard: mem_sel_data=1, meaning the s2 entry is valid with is_mem=1. The memory address mux serves data, so the fetch slot is lost.
- mem_sel_data is registered: it equals the s1 entry's valid&is_mem captured on the advance that moves that entry into s2.
- issue = sf_valid & !flush & !raw_hazard & !mem_sel_data & (state==RUN).
- pc_hold = !issue & !flush. flush always lets the PC be redirected.
- Priority, highest first: rst > flush > drain/IDLE > structural > RAW.
- stall_count increments on each advance where sf_valid=1 & !flush & issue=0. It saturates at all-ones.
- FSM:
  - RUN: issues normally. drain_req=1 goes to DRAIN on the next advance.
  - DRAIN: issue=0. Goes to IDLE on the advance where all s0..s3 valid=0 after the shift.
  - IDLE: drained=1. drain_req=0 goes to RUN on the next advance.
  - drain_req dropped during DRAIN: still completes to IDLE, then returns to RUN.
- Back-to-back dependency, e.g. an s0 producer: 3 stall advances, then issue when the producer reaches s3.

Test Plan:
- Independent stream: add x1, add x2, add x3, no deps -> issue=1 every advance; stall_count=0; pc_hold=0.
- RAW: add x5,... then add x6,x5,x0 next -> 3 advances with issue=0, pc_hold=1; issue on 4th; stall_count=3.
- x0 dest: producer rd=0 followed by consumer rs1=0 -> no stall.
- Load in s2: lw enters s2 -> mem_sel_data=1 for exactly one advance; a simultaneous independent sf instruction gets issue=0 and stall_count+1.
- Flush during RAW stall -> issue=0, pc_hold=0, stall_count unchanged; the consumer never enters s0.
- Drain: drain_req with 3 in-flight entries -> drained=1 after 4 advances with no new issue. Deassert drain_req -> RUN and issue on the next advance. Reset mid-drain -> all valids=0, drained=0, state RUN.

Source files
------------

// File: rtl/hazard_scheduler.sv
// Issue/stall scheduler for the sf -> s0..s3 pipeline: RAW scoreboard, memory
// port arbitration between fetch and s2 data access, and a RUN/DRAIN/IDLE mode FSM.
module hazard_scheduler #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_enable,
  input  logic                   sf_valid,
  input  logic [REG_ADDR_W-1:0]  sf_rs1,
  input  logic [REG_ADDR_W-1:0]  sf_rs2,
  input  logic                   sf_uses_rs1,
  input  logic                   sf_uses_rs2,
  input  logic [REG_ADDR_W-1:0]  sf_rd,
  input  logic                   sf_writes_rd,
  input  logic                   sf_is_mem,
  input  logic                   flush,
  input  logic                   drain_req,
  output logic                   issue,
  output logic                   pc_hold,
  output logic                   mem_sel_data,
  output logic                   drained,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  writes_rd;
    logic                  is_mem;
  } entry_t;

  localparam int NUM_STAGES = 4;

  state_t state_q, state_d;
  entry_t stage_q [NUM_STAGES];
  entry_t sf_entry;
  logic   raw_hazard;
  logic   stall_inc;
  logic   pipe_empty_next;

  assign sf_entry = '{valid: 1'b1, rd: sf_rd, writes_rd: sf_writes_rd, is_mem: sf_is_mem};

  // s3 is excluded: the register file writes in the first half and reads in the second.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    raw_hazard = 1'b0;
    for (int i = 0; i < NUM_STAGES - 1; i++) begin
      if (stage_q[i].valid && stage_q[i].writes_rd) begin
        if (sf_uses_rs1 && (sf_rs1 != '0) && (sf_rs1 == stage_q[i].rd)) raw_hazard = 1'b1;
        if (sf_uses_rs2 && (sf_rs2 != '0) && (sf_rs2 == stage_q[i].rd)) raw_hazard = 1'b1;
      end
    end
  end

  assign issue     = sf_valid & ~flush & ~raw_hazard & ~mem_sel_data & (state_q == RUN);
  assign pc_hold   = ~issue & ~flush;
  assign stall_inc = sf_valid & ~flush & ~issue;
  assign drained   = (state_q == IDLE);

  // True when s0..s3 will all be bubbles once the current advance has shifted.
  assign pipe_empty_next = ~issue & ~stage_q[0].valid & ~stage_q[1].valid & ~stage_q[2].valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (drain_req)       state_d = DRAIN;
      DRAIN:   if (pipe_empty_next) state_d = IDLE;
      IDLE:    if (!drain_req)      state_d = RUN;
      default:                      state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and the stage shift below needs no ordering care.
    if (rst) begin
      state_q      <= RUN;
      mem_sel_data <= 1'b0;
      stall_count  <= '0;
      // NOTE: the scoreboard is a handful of flops, not a RAM, so it is reset in
      // full; a stale valid bit after reset would create phantom hazards.
      for (int i = 0; i < NUM_STAGES; i++) stage_q[i] <= '0;
    end else if (clk_enable) begin
      state_q      <= state_d;
      stage_q[0]   <= issue ? sf_entry : '0;
      for (int i = 1; i < NUM_STAGES; i++) stage_q[i] <= stage_q[i-1];
      // Registered so the address mux select is stable for the whole s2 cycle.
      mem_sel_data <= stage_q[1].valid & stage_q[1].is_mem;
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed, table-driven bench for hazard_scheduler; counter width is narrowed
// so the saturation boundary is reachable in a short run.
module tb_hazard_scheduler;

  localparam int RW  = 5;
  localparam int SCW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           clk_enable;
  logic           sf_valid;
  logic [RW-1:0]  sf_rs1, sf_rs2, sf_rd;
  logic           sf_uses_rs1, sf_uses_rs2, sf_writes_rd, sf_is_mem;
  logic           flush, drain_req;
  logic           issue, pc_hold, mem_sel_data, drained;
  logic [SCW-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  hazard_scheduler #(.REG_ADDR_W(RW), .STALL_CNT_W(SCW)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_enable   (clk_enable),
    .sf_valid     (sf_valid),
    .sf_rs1       (sf_rs1),
    .sf_rs2       (sf_rs2),
    .sf_uses_rs1  (sf_uses_rs1),
    .sf_uses_rs2  (sf_uses_rs2),
    .sf_rd        (sf_rd),
    .sf_writes_rd (sf_writes_rd),
    .sf_is_mem    (sf_is_mem),
    .flush        (flush),
    .drain_req    (drain_req),
    .issue        (issue),
    .pc_hold      (pc_hold),
    .mem_sel_data (mem_sel_data),
    .drained      (drained),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sv;
    logic [RW-1:0] rs1;
    logic          u1;
    logic [RW-1:0] rs2;
    logic          u2;
    logic [RW-1:0] rd;
    logic          wr;
    logic          mem;
    logic          fl;
    logic          dr;
    logic          en;
    logic          e_issue;
    logic          e_hold;
    logic          e_mem;
    logic          e_drained;
    logic [SCW-1:0] e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sv, input int rs1, input logic u1,
                              input int rs2, input logic u2, input int rd,
                              input logic wr, input logic mem, input logic fl,
                              input logic dr, input logic en, input logic ei,
                              input logic eh, input logic em, input logic ed,
                              input int es);
    vec_t r;
    r.sv = sv;  r.rs1 = rs1[RW-1:0]; r.u1 = u1; r.rs2 = rs2[RW-1:0]; r.u2 = u2;
    r.rd = rd[RW-1:0]; r.wr = wr; r.mem = mem; r.fl = fl; r.dr = dr; r.en = en;
    r.e_issue = ei; r.e_hold = eh; r.e_mem = em; r.e_drained = ed;
    r.e_stall = es[SCW-1:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input int rs1, input logic u1, input int rs2,
                       input logic u2, input int rd, input logic wr, input logic mem,
                       input logic fl, input logic dr, input logic en);
    sf_valid = sv; sf_rs1 = rs1[RW-1:0]; sf_uses_rs1 = u1;
    sf_rs2 = rs2[RW-1:0]; sf_uses_rs2 = u2; sf_rd = rd[RW-1:0];
    sf_writes_rd = wr; sf_is_mem = mem; flush = fl; drain_req = dr; clk_enable = en;
  endtask

  initial begin
    // sv rs1 u1 rs2 u2 rd wr mem fl dr en | issue hold mem drained stall
    // Independent stream
    vecs.push_back(mk(1, 10,1, 11,1,  1,1,0, 0,0,1,  1,0,0,0, 0));
    vecs.push_back(mk(1, 10,1, 11,1,  2,1,0, 0,0,1,  1,0,0,0, 0));
    vecs.push_back(mk(1, 10,1, 11,1,  3,1,0, 0,0,1,  1,0,0,0, 0));
    // Producer x5 then back-to-back consumer x6 = x5 + x0
    vecs.push_back(mk(1, 10,1, 11,1,  5,1,0, 0,0,1,  1,0,0,0, 0));
    vecs.push_back(mk(1,  5,1,  0,1,  6,1,0, 0,0,1,  0,1,0,0, 0));
    vecs.push_back(mk(1,  5,1,  0,1,  6,1,0, 0,0,1,  0,1,0,0, 1));
    vecs.push_back(mk(1,  5,1,  0,1,  6,1,0, 0,0,1,  0,1,0,0, 2));
    vecs.push_back(mk(1,  5,1,  0,1,  6,1,0, 0,0,1,  1,0,0,0, 3));
    // rd=0 producer, rs=0 consumer: no stall
    vecs.push_back(mk(1, 10,1, 11,1,  0,1,0, 0,0,1,  1,0,0,0, 3));
    vecs.push_back(mk(1,  0,1,  0,1,  7,1,0, 0,0,1,  1,0,0,0, 3));
    // Load travels to s2, then steals the fetch slot for one advance
    vecs.push_back(mk(1, 10,1,  0,0,  8,1,1, 0,0,1,  1,0,0,0, 3));
    vecs.push_back(mk(0,  0,0,  0,0,  0,0,0, 0,0,1,  0,1,0,0, 3));
    vecs.push_back(mk(0,  0,0,  0,0,  0,0,0, 0,0,1,  0,1,0,0, 3));
    vecs.push_back(mk(1, 10,1, 11,1,  9,1,0, 0,0,1,  0,1,1,0, 3));
    vecs.push_back(mk(1, 10,1, 11,1,  9,1,0, 0,0,1,  1,0,0,0, 4));
    // Flush during RAW stall; killed x12 must never reach the scoreboard
    vecs.push_back(mk(1,  9,1, 11,1, 12,1,0, 0,0,1,  0,1,0,0, 4));
    vecs.push_back(mk(1,  9,1, 11,1, 12,1,0, 1,0,1,  0,0,0,0, 5));
    vecs.push_back(mk(0,  0,0,  0,0,  0,0,0, 0,0,1,  0,1,0,0, 5));
    vecs.push_back(mk(1, 12,1, 11,1, 13,1,0, 0,0,1,  1,0,0,0, 5));
    // Three in flight, then drain; drain_req drops mid-DRAIN
    vecs.push_back(mk(1, 10,1, 11,1, 14,1,0, 0,0,1,  1,0,0,0, 5));
    vecs.push_back(mk(1, 10,1, 11,1, 15,1,0, 0,0,1,  1,0,0,0, 5));
    vecs.push_back(mk(0,  0,0,  0,0,  0,0,0, 0,1,1,  0,1,0,0, 5));
    vecs.push_back(mk(1, 10,1, 11,1, 16,1,0, 0,1,1,  0,1,0,0, 5));
    vecs.push_back(mk(0,  0,0,  0,0,  0,0,0, 0,1,1,  0,1,0,0, 6));
    vecs.push_back(mk(0,  0,0,  0,0,  0,0,0, 0,0,1,  0,1,0,0, 6));
    vecs.push_back(mk(1, 10,1, 11,1, 16,1,0, 0,0,1,  0,1,0,1, 6));
    vecs.push_back(mk(1, 10,1, 11,1, 16,1,0, 0,0,1,  1,0,0,0, 7));
    // clk_enable low freezes state; then counter saturates at all-ones
    vecs.push_back(mk(1, 16,1, 11,1, 17,1,0, 0,0,0,  0,1,0,0, 7));
    vecs.push_back(mk(1, 16,1, 11,1, 17,1,0, 1,0,0,  0,0,0,0, 7));
    vecs.push_back(mk(1, 16,1, 11,1, 17,1,0, 0,0,1,  0,1,0,0, 7));
    vecs.push_back(mk(1, 16,1, 11,1, 17,1,0, 0,0,1,  0,1,0,0, 7));

    // Reset asserted with clk_enable high: reset must win
    rst = 1'b1;
    drive(0, 0,0, 0,0, 0,0,0, 0,0,1);
    repeat (3) @(negedge clk);
    #1;
    check("reset stall_count", 32'(stall_count), 32'd0);
    check("reset mem_sel_data", 32'(mem_sel_data), 32'd0);
    check("reset drained", 32'(drained), 32'd0);
    check("reset pc_hold", 32'(pc_hold), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].sv, 32'(vecs[i].rs1), vecs[i].u1, 32'(vecs[i].rs2), vecs[i].u2,
            32'(vecs[i].rd), vecs[i].wr, vecs[i].mem, vecs[i].fl, vecs[i].dr, vecs[i].en);
      #1;
      check($sformatf("v%0d issue", i), 32'(issue), 32'(vecs[i].e_issue));
      check($sformatf("v%0d pc_hold", i), 32'(pc_hold), 32'(vecs[i].e_hold));
      check($sformatf("v%0d mem_sel_data", i), 32'(mem_sel_data), 32'(vecs[i].e_mem));
      check($sformatf("v%0d drained", i), 32'(drained), 32'(vecs[i].e_drained));
      check($sformatf("v%0d stall_count", i), 32'(stall_count), 32'(vecs[i].e_stall));
    end

    // Reset mid-drain with a load sitting in s2
    @(negedge clk);
    drive(1, 10,1, 0,0, 20,1,1, 0,0,1);
    #1;
    check("md lw issue", 32'(issue), 32'd1);
    @(negedge clk);
    drive(1, 10,1, 11,1, 21,1,0, 0,0,1);
    #1;
    check("md add issue", 32'(issue), 32'd1);
    @(negedge clk);
    drive(0, 0,0, 0,0, 0,0,0, 0,1,1);
    @(negedge clk);
    drive(1, 21,1, 20,1, 22,1,0, 0,1,1);
    #1;
    check("md mem_sel_data", 32'(mem_sel_data), 32'd1);
    check("md drain issue", 32'(issue), 32'd0);
    check("md drained", 32'(drained), 32'd0);
    rst = 1'b1;
    clk_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drain_req = 1'b0;
    #1;
    check("post-rst mem_sel_data", 32'(mem_sel_data), 32'd0);
    check("post-rst drained", 32'(drained), 32'd0);
    check("post-rst stall_count", 32'(stall_count), 32'd0);
    check("post-rst issue", 32'(issue), 32'd1);
    check("post-rst pc_hold", 32'(pc_hold), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
